// File: rtl/dual_down_counter_pkg.sv
// dual_counter_pkg: shared types and constants for the dual up/down nibble counters
package dual_counter_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] DIGIT_MAX = 4'hF;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/dual_down_counter_if.sv
// dual_down_counter_if: load handshake, run controls and count/status view of the down-counter
interface dual_down_counter_if import dual_counter_pkg::*; ();
  logic                  load_valid;
  logic                  load_ready;
  logic [2*NIBBLE_W-1:0] load_value;
  logic                  en;
  logic                  auto_reload;
  logic                  abort;
  logic [NIBBLE_W-1:0]   count_lo;
  logic [NIBBLE_W-1:0]   count_hi;
  logic [2*NIBBLE_W-1:0] out;
  logic                  tc;
  logic                  busy;
  modport master (
    output load_valid, load_value, en, auto_reload, abort,
    input  load_ready, count_lo, count_hi, out, tc, busy
  );
  modport slave (
    input  load_valid, load_value, en, auto_reload, abort,
    output load_ready, count_lo, count_hi, out, tc, busy
  );
endinterface

// File: rtl/dual_down_counter_cell.sv
// nibble_down_cell: one digit with synchronous load and decrement-on-borrow_in, wrapping 0 to DIGIT_MAX
module nibble_down_cell import dual_counter_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NIBBLE_W-1:0] load_val,
  input  logic                borrow_in,
  output logic [NIBBLE_W-1:0] digit,
  output logic                borrow_out
);
  assign borrow_out = borrow_in && digit == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit <= '0;
    else if (load) digit <= load_val;
    else if (borrow_in) digit <= borrow_out ? DIGIT_MAX : digit - NIBBLE_W'(1);
  end
endmodule

// File: rtl/dual_down_counter.sv
// dual_down_counter: loadable hi:lo down-counter with terminal-count pulse and optional auto-reload
module dual_down_counter import dual_counter_pkg::*; (
  input logic clk,
  input logic rst_n,
  dual_down_counter_if.slave bus
);
  state_t                state, state_nx;
  logic [2*NIBBLE_W-1:0] reload_reg, ld_val;
  logic                  ld, cap, dec, tc_d, zero, lo_borrow, hi_borrow;
  assign zero           = {bus.count_hi, bus.count_lo} == '0;
  assign bus.load_ready = state == IDLE;
  assign bus.busy       = state == RUN;
  // abort wins over terminal, which wins over decrement, so the count never wraps below zero
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    cap      = 1'b0;
    dec      = 1'b0;
    tc_d     = 1'b0;
    ld_val   = bus.load_value;
    if (state == IDLE) begin
      if (bus.load_valid) begin
        ld       = 1'b1;
        cap      = 1'b1;
        state_nx = RUN;
      end
    end else if (bus.abort) begin
      ld       = 1'b1;
      ld_val   = '0;
      state_nx = IDLE;
    end else if (bus.en && zero) begin
      tc_d     = 1'b1;
      ld       = bus.auto_reload;
      ld_val   = reload_reg;
      state_nx = bus.auto_reload ? RUN : IDLE;
    end else begin
      dec = bus.en;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      reload_reg <= '0;
      bus.tc     <= 1'b0;
      bus.out    <= '0;
    end else begin
      state      <= state_nx;
      bus.tc     <= tc_d;
      bus.out    <= {bus.count_hi, bus.count_lo};
      if (cap) reload_reg <= bus.load_value;
    end
  end
  nibble_down_cell u_lo (
    .clk(clk), .rst_n(rst_n), .load(ld), .load_val(ld_val[NIBBLE_W-1:0]),
    .borrow_in(dec), .digit(bus.count_lo), .borrow_out(lo_borrow)
  );
  nibble_down_cell u_hi (
    .clk(clk), .rst_n(rst_n), .load(ld), .load_val(ld_val[2*NIBBLE_W-1:NIBBLE_W]),
    .borrow_in(lo_borrow), .digit(bus.count_hi), .borrow_out(hi_borrow)
  );
  logic unused_borrow;
  assign unused_borrow = hi_borrow;
endmodule

// File: tb/tb_dual_down_counter.sv
// tb_dual_down_counter: table-driven vectors plus hand-written multi-cycle sequences
module tb_dual_down_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  dual_down_counter_if bus();
  dual_down_counter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic       lv;
    logic [7:0] val;
    logic       en;
    logic       ar;
    logic       ab;
    logic [7:0] cnt;
    logic [7:0] outv;
    logic       tc;
    logic       busy;
  } vec_t;
  vec_t tbl [23];
  task automatic check(input string name, input logic [7:0] cnt, input logic [7:0] outv,
                       input logic tc, input logic busy);
    nvec++;
    if ({bus.count_hi, bus.count_lo} !== cnt || bus.out !== outv || bus.tc !== tc ||
        bus.busy !== busy || bus.load_ready !== !busy) begin
      nerr++;
      $display("FAIL %s: got cnt=%h out=%h tc=%b busy=%b ready=%b, want cnt=%h out=%h tc=%b busy=%b ready=%b",
               name, {bus.count_hi, bus.count_lo}, bus.out, bus.tc, bus.busy, bus.load_ready,
               cnt, outv, tc, busy, !busy);
    end
  endtask
  task automatic drive(input logic lv, input logic [7:0] val, input logic en, input logic ar, input logic ab);
    bus.load_valid = lv; bus.load_value = val; bus.en = en; bus.auto_reload = ar; bus.abort = ab;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    check("reset_hold", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("reset_release", 8'h00, 8'h00, 1'b0, 1'b0);
  endtask
  logic [7:0] pat [3];
  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[0]  = '{1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1};
    tbl[1]  = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0};
    tbl[2]  = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0};
    tbl[3]  = '{1, 8'h05, 0, 0, 0, 8'h05, 8'h00, 0, 1};
    tbl[4]  = '{1, 8'hAA, 1, 0, 0, 8'h04, 8'h05, 0, 1};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 0, 1};
    tbl[6]  = '{1, 8'h33, 1, 0, 0, 8'h03, 8'h04, 0, 1};
    tbl[7]  = '{0, 8'h00, 0, 0, 0, 8'h03, 8'h03, 0, 1};
    tbl[8]  = '{0, 8'h00, 1, 0, 0, 8'h02, 8'h03, 0, 1};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 8'h02, 8'h02, 0, 1};
    tbl[10] = '{0, 8'h00, 1, 0, 0, 8'h01, 8'h02, 0, 1};
    tbl[11] = '{0, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 1};
    tbl[12] = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h01, 0, 1};
    tbl[13] = '{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1};
    tbl[14] = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0};
    tbl[15] = '{1, 8'h03, 1, 0, 0, 8'h03, 8'h00, 0, 1};
    tbl[16] = '{0, 8'h00, 1, 0, 0, 8'h02, 8'h03, 0, 1};
    tbl[17] = '{0, 8'h00, 1, 0, 0, 8'h01, 8'h02, 0, 1};
    tbl[18] = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h01, 0, 1};
    tbl[19] = '{0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 0, 0};
    tbl[20] = '{1, 8'h37, 0, 0, 1, 8'h37, 8'h00, 0, 1};
    tbl[21] = '{0, 8'h00, 1, 0, 1, 8'h00, 8'h37, 0, 0};
    tbl[22] = '{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0};
    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].lv, tbl[i].val, tbl[i].en, tbl[i].ar, tbl[i].ab);
      tick();
      check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].outv, tbl[i].tc, tbl[i].busy);
    end
    do_reset();
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    tick();
    check("load12", 8'h12, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("down12_%0d", k), 8'(18 - k), 8'(19 - k), 1'b0, 1'b1);
    end
    tick();
    check("tc12", 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    check("after_tc12", 8'h00, 8'h00, 1'b0, 1'b0);
    pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h02;
    drive(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    tick();
    check("load02_ar", 8'h02, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("reload_%0d", i), pat[(i - 1) % 3], i == 1 ? 8'h02 : pat[(i + 1) % 3],
            i % 3 == 0, 1'b1);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    check("reload_abort", 8'h00, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("pre_async", 8'h0F, 8'h10, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("async_release", 8'h00, 8'h00, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
